sram_like_arbiter: RTL

Two-master, one-slave arbiter for the SRAM-like bus (req/addr_ok/data_ok). It shares one slave port between the instruction-fetch requester (IF stage) and the data requester (EXE stage load/store port). Each address phase is forwarded to the slave with a lock until accepted. A small in-order ID FIFO records which master owns each outstanding transaction, and each data_ok/rdata is returned to that master. It sits between the CPU pipeline and the downstream bus bridge.

---
 rtl/sram_like_pkg.sv | 28 ++
 rtl/sram_like_id_fifo.sv | 54 +++++
 rtl/sram_like_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/sram_like_pkg.sv
// Shared definitions for the SRAM-like bus arbiter: bus widths, size codes,
// master IDs and the grant state type.
package sram_like_pkg;

    localparam int SRAM_ADDR_W = 32;
    localparam int SRAM_DATA_W = 32;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    localparam logic MASTER_INST = 1'b0;
    localparam logic MASTER_DATA = 1'b1;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_t;

    // A lone requester wins; on a tie the master that did not win last time wins.
    function automatic logic rr_pick(input logic inst_req, input logic data_req,
                                     input logic last_grant);
        if (inst_req && !data_req) return MASTER_INST;
        if (data_req && !inst_req) return MASTER_DATA;
        return ~last_grant;
    endfunction

endpackage

// File: rtl/sram_like_id_fifo.sv
// In-order FIFO of 1-bit owner IDs, one entry per accepted-but-unanswered
// transaction. DEPTH must be a power of two so the pointers wrap naturally.
module sram_like_id_fifo #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic push_id,
    input  logic pop,
    output logic full,
    output logic empty,
    output logic head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = DEPTH[PTR_W:0];

    logic [DEPTH-1:0] mem_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == DEPTH_C);
    assign empty   = (count_q == '0);
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_id;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/sram_like_arbiter.sv
// Two-master (inst/data) to one-slave arbiter for the SRAM-like bus with
// address-phase locking and in-order response routing.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ARB_IDLE | no address phase pending; round-robin select each cycle
//   ARB_LOCK | owner_q's request was presented but not yet accepted
module sram_like_arbiter
    import sram_like_pkg::*;
#(
    parameter int OUTSTANDING = 4
) (
    input  logic                   clk,
    input  logic                   reset,

    input  logic                   inst_req,
    input  logic                   inst_wr,
    input  logic [1:0]             inst_size,
    input  logic [3:0]             inst_wstrb,
    input  logic [SRAM_ADDR_W-1:0] inst_addr,
    input  logic [SRAM_DATA_W-1:0] inst_wdata,
    output logic                   inst_addr_ok,
    output logic                   inst_data_ok,
    output logic [SRAM_DATA_W-1:0] inst_rdata,

    input  logic                   data_req,
    input  logic                   data_wr,
    input  logic [1:0]             data_size,
    input  logic [3:0]             data_wstrb,
    input  logic [SRAM_ADDR_W-1:0] data_addr,
    input  logic [SRAM_DATA_W-1:0] data_wdata,
    output logic                   data_addr_ok,
    output logic                   data_data_ok,
    output logic [SRAM_DATA_W-1:0] data_rdata,

    output logic                   req,
    output logic                   wr,
    output logic [1:0]             size,
    output logic [3:0]             wstrb,
    output logic [SRAM_ADDR_W-1:0] addr,
    output logic [SRAM_DATA_W-1:0] wdata,
    input  logic                   addr_ok,
    input  logic                   data_ok,
    input  logic [SRAM_DATA_W-1:0] rdata,

    output logic                   protocol_err
);

    arb_state_t state_q, state_d;
    logic       owner_q, owner_d;
    logic       last_grant_q, last_grant_d;
    logic       sel;
    logic       sel_req;
    logic       req_int;
    logic       accept;
    logic       resp_ok;
    logic       err_q;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_head;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;

        sel = (state_q == ARB_LOCK) ? owner_q
                                    : rr_pick(inst_req, data_req, last_grant_q);
        sel_req = (sel == MASTER_DATA) ? data_req : inst_req;

        // Full depends only on registered count, so data_ok never reaches req.
        req_int = sel_req && !fifo_full && !reset;
        accept  = req_int && addr_ok;

        if (accept) begin
            state_d      = ARB_IDLE;
            last_grant_d = sel;
        end else if (req_int) begin
            state_d = ARB_LOCK;
            owner_d = sel;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ARB_IDLE;
            owner_q      <= MASTER_INST;
            last_grant_q <= MASTER_INST;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            if (data_ok && fifo_empty) begin
                err_q <= 1'b1;
            end
        end
    end

    assign resp_ok = data_ok && !fifo_empty && !reset;

    sram_like_id_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_id_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (accept),
        .push_id (sel),
        .pop     (resp_ok),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .head    (fifo_head)
    );

    assign req          = req_int;
    assign wr           = reset ? 1'b0 : ((sel == MASTER_DATA) ? data_wr    : inst_wr);
    assign size         = reset ? '0   : ((sel == MASTER_DATA) ? data_size  : inst_size);
    assign wstrb        = reset ? '0   : ((sel == MASTER_DATA) ? data_wstrb : inst_wstrb);
    assign addr         = reset ? '0   : ((sel == MASTER_DATA) ? data_addr  : inst_addr);
    assign wdata        = reset ? '0   : ((sel == MASTER_DATA) ? data_wdata : inst_wdata);

    assign inst_addr_ok = accept && (sel == MASTER_INST);
    assign data_addr_ok = accept && (sel == MASTER_DATA);

    assign inst_data_ok = resp_ok && (fifo_head == MASTER_INST);
    assign data_data_ok = resp_ok && (fifo_head == MASTER_DATA);
    assign inst_rdata   = reset ? '0 : rdata;
    assign data_rdata   = reset ? '0 : rdata;

    assign protocol_err = err_q && !reset;

endmodule
